// File: rtl/spi_peripheral.sv
// SPI responder (mode 0) running entirely in the system clock domain.
// SCLK/CS/MOSI are oversampled through synchronizer chains. Each WIDTH-bit
// word is shifted in from MOSI and out on MISO, MSB first, with one-cycle
// strobes for word completion, transmit-buffer capture and aborted frames.
module spi_peripheral #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             SCLK_i,
  input  logic             CS_i,
  input  logic             MOSI_i,
  output logic             MISO_o,
  output logic             MISO_oe_o,
  input  logic [WIDTH-1:0] tx_buffer_i,
  output logic             tx_load_o,
  output logic [WIDTH-1:0] rx_buffer_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             frame_error_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // Two-bit encoding leaves spare codes; any of them falls back to IDLE.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  // Synchronizer chains: bit 0 samples the pin, the top bit is the clean value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             reload_pending_q, reload_pending_d;
  logic [WIDTH-1:0] rx_buffer_q, rx_buffer_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;
  logic             tx_load;

  logic             sclk_now, cs_now, mosi_now;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CNT_W-1:0] cnt_base;

  assign sclk_now  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_now    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_now  = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_now & ~sclk_prev_q;
  assign sclk_fall = ~sclk_now & sclk_prev_q;
  assign cs_rise   = cs_now & ~cs_prev_q;
  assign cs_fall   = ~cs_now & cs_prev_q;

  // Advance the synchronizer chains and remember the previous clean samples.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
    sclk_prev_d = sclk_now;
    cs_prev_d   = cs_now;
  end

  // Protocol FSM: frame start/stop, bit shifting, word completion and reload.
  always_comb begin
    state_d          = state_q;
    tx_shift_d       = tx_shift_q;
    rx_shift_d       = rx_shift_q;
    bit_cnt_d        = bit_cnt_q;
    reload_pending_d = reload_pending_q;
    rx_buffer_d      = rx_buffer_q;
    rx_valid_d       = 1'b0;
    frame_error_d    = 1'b0;
    tx_load          = 1'b0;
    cnt_base         = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // SCLK activity is ignored until the master selects us.
        if (cs_rise) begin
          tx_shift_d       = tx_buffer_i;
          tx_load          = 1'b1;
          bit_cnt_d        = '0;
          reload_pending_d = 1'b0;
          state_d          = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // A full word was assembled on the previous rise: publish it and
        // arm the reload so the next falling edge presents the next MSB.
        if (bit_cnt_q == CNT_FULL) begin
          rx_buffer_d      = rx_shift_q;
          rx_valid_d       = 1'b1;
          bit_cnt_d        = '0;
          cnt_base         = '0;
          reload_pending_d = 1'b1;
        end

        if (cs_fall) begin
          // Deselect wins over any SCLK edge seen in the same cycle.
          state_d          = ST_IDLE;
          reload_pending_d = 1'b0;
          bit_cnt_d        = '0;
          if ((bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL)) begin
            frame_error_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_now};
          bit_cnt_d  = cnt_base + CNT_W'(1);
        end else if (sclk_fall) begin
          if (reload_pending_q) begin
            tx_shift_d       = tx_buffer_i;
            tx_load          = 1'b1;
            reload_pending_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered pin-facing outputs follow the current state.
  always_comb begin
    miso_d = (state_q == ST_SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
    busy_d = (state_q == ST_SHIFT);
  end

  // All state, asynchronously cleared to the deselected / SCLK-low condition.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q      <= '0;
      cs_sync_q        <= '0;
      mosi_sync_q      <= '0;
      sclk_prev_q      <= 1'b0;
      cs_prev_q        <= 1'b0;
      state_q          <= ST_IDLE;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      bit_cnt_q        <= '0;
      reload_pending_q <= 1'b0;
      rx_buffer_q      <= '0;
      rx_valid_q       <= 1'b0;
      frame_error_q    <= 1'b0;
      miso_q           <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      sclk_sync_q      <= sclk_sync_d;
      cs_sync_q        <= cs_sync_d;
      mosi_sync_q      <= mosi_sync_d;
      sclk_prev_q      <= sclk_prev_d;
      cs_prev_q        <= cs_prev_d;
      state_q          <= state_d;
      tx_shift_q       <= tx_shift_d;
      rx_shift_q       <= rx_shift_d;
      bit_cnt_q        <= bit_cnt_d;
      reload_pending_q <= reload_pending_d;
      rx_buffer_q      <= rx_buffer_d;
      rx_valid_q       <= rx_valid_d;
      frame_error_q    <= frame_error_d;
      miso_q           <= miso_d;
      busy_q           <= busy_d;
    end
  end

  assign MISO_o        = miso_q;
  assign MISO_oe_o     = busy_q;
  assign busy_o        = busy_q;
  assign tx_load_o     = tx_load;
  assign rx_buffer_o   = rx_buffer_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_error_o = frame_error_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench acting as a mode-0 SPI master around spi_peripheral. Expected data
// comes from word queues: every MOSI word of a complete frame must appear
// on rx_buffer_o in order, and the MISO stream of word j must equal the
// j-th transmit word offered on tx_buffer_i.
module tb_spi_peripheral;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         cs = 1'b0;
  logic         mosi = 1'b0;
  logic         miso, miso_oe, tx_load, rx_valid, busy, ferr;
  logic [W-1:0] tx_buffer = '0;
  logic [W-1:0] rx_buffer;

  int n_vec = 0;
  int n_err = 0;
  int n_load = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_words = 0;

  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] last_rx = '0;
  logic [W-1:0] tw[0:7];
  logic [W-1:0] mw[0:7];

  spi_peripheral #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .SCLK_i       (sclk),
    .CS_i         (cs),
    .MOSI_i       (mosi),
    .MISO_o       (miso),
    .MISO_oe_o    (miso_oe),
    .tx_buffer_i  (tx_buffer),
    .tx_load_o    (tx_load),
    .rx_buffer_o  (rx_buffer),
    .rx_valid_o   (rx_valid),
    .busy_o       (busy),
    .frame_error_o(ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (tx_load) n_load++;
    if (ferr) n_ferr++;
    if (rx_valid) begin
      n_valid++;
      if (rx_exp_q.size() == 0) chk("rx_spurious", 32'(rx_buffer), 32'hFFFF_FFFF);
      else chk("rx_word", 32'(rx_buffer), 32'(rx_exp_q.pop_front()));
    end
  end

  // Shift nbits of w MSB first; MISO is sampled just before each rise.
  // next_tx is presented on tx_buffer after the first low phase.
  task automatic send_bits(input logic [W-1:0] w, input int nbits, input int half,
                           input int first_low, input logic [W-1:0] next_tx,
                           output logic [W-1:0] got);
    got = '0;
    for (int b = 0; b < nbits; b++) begin
      mosi = w[W-1-b];
      tick(b == 0 ? first_low : half);
      if (b == 0) tx_buffer = next_tx;
      got = {got[W-2:0], miso};
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  // Complete frame of nw words using mw[] (MOSI) and tw[] (transmit words).
  task automatic frame(input int nw, input int half, input int setup);
    int l0, v0, f0;
    logic [W-1:0] got;
    l0 = n_load; v0 = n_valid; f0 = n_ferr;
    for (int j = 0; j < nw; j++) rx_exp_q.push_back(mw[j]);
    tx_buffer = tw[0];
    cs = 1'b1;
    for (int j = 0; j < nw; j++) begin
      send_bits(mw[j], W, half, (j == 0) ? setup : half, tw[j+1], got);
      chk("miso_word", 32'(got), 32'(tw[j]));
      $display("word %0d: miso %h (want %h) mosi %h", n_words, got, tw[j], mw[j]);
      n_words++;
    end
    tick(half);
    cs = 1'b0;
    tick(8);
    last_rx = mw[nw-1];
    chk("tx_load_cnt", 32'(n_load - l0), 32'(nw + 1));
    chk("rx_valid_cnt", 32'(n_valid - v0), 32'(nw));
    chk("frame_err_cnt", 32'(n_ferr - f0), 32'd0);
    chk("rx_hold", 32'(rx_buffer), 32'(last_rx));
    chk("deselected", {29'd0, miso_oe, busy, miso}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, v0, f0, total, nw;
    logic [W-1:0] got;

    // Reset state
    tick(3);
    chk("reset_state", {18'd0, miso, miso_oe, tx_load, rx_buffer, rx_valid, busy, ferr}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Single word: transmit 0xA5, receive 0x3C, SCLK = clock/16
    tw[0] = 8'hA5; tw[1] = 8'h00; mw[0] = 8'h3C;
    frame(1, 8, 8);

    // Back-to-back words without deselect
    tw[0] = 8'h55; tw[1] = 8'hC3; tw[2] = 8'h00; mw[0] = 8'h01; mw[1] = 8'hFE;
    frame(2, 8, 8);

    // Abort after three rises
    l0 = n_load; v0 = n_valid; f0 = n_ferr;
    tx_buffer = 8'h3A;
    cs = 1'b1;
    send_bits(8'hE7, 3, 6, 6, 8'h3A, got);
    tick(6);
    cs = 1'b0;
    tick(8);
    chk("abort_ferr", 32'(n_ferr - f0), 32'd1);
    chk("abort_valid", 32'(n_valid - v0), 32'd0);
    chk("abort_load", 32'(n_load - l0), 32'd1);
    chk("abort_rx_hold", 32'(rx_buffer), 32'(last_rx));
    chk("abort_idle", {30'd0, miso_oe, busy}, 32'd0);

    // SCLK toggling while deselected
    l0 = n_load; v0 = n_valid;
    for (int p = 0; p < 10; p++) begin
      mosi = 1'(p);
      tick(5);
      chk("idle_miso", {31'd0, miso}, 32'd0);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(6);
    chk("idle_load", 32'(n_load - l0), 32'd0);
    chk("idle_valid", 32'(n_valid - v0), 32'd0);
    tw[0] = 8'h6E; tw[1] = 8'h00; mw[0] = 8'hB1;
    frame(1, 6, 6);

    // Asynchronous reset after bit 5 of a word
    tx_buffer = 8'hF0;
    cs = 1'b1;
    send_bits(8'h5A, 5, 6, 6, 8'hF0, got);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", {18'd0, miso, miso_oe, tx_load, rx_buffer, rx_valid, busy, ferr}, 32'd0);
    cs = 1'b0;
    tick(3);
    rst = 1'b0;
    last_rx = '0;
    tick(4);
    tw[0] = 8'($urandom); tw[1] = 8'($urandom); mw[0] = 8'h96;
    frame(1, 7, 7);

    // Randomized traffic: 100 words in frames of 1..6 words
    total = 0;
    while (total < 100) begin
      nw = int'($urandom_range(1, 6));
      if (nw > 100 - total) nw = 100 - total;
      for (int j = 0; j <= nw; j++) begin
        tw[j] = 8'($urandom);
        mw[j] = 8'($urandom);
      end
      frame(nw, int'($urandom_range(4, 9)), int'($urandom_range(5, 10)));
      total += nw;
    end

    chk("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
